// File: rtl/stream_frame_reader.sv
// ============================================================================
// Module   : stream_frame_reader
// Brief    : Synchronizes the host strobe, parses typed frames and emits
//            key/data byte pulses. Optional macro: READER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_frame_reader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] in_byte,
    input  logic       in_strobe,
    output logic [7:0] input_byte_pulsed,
    output logic       is_key_pulsed,
    output logic       input_pulse,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [0:0] c_st_hdr     = 1'b0;
    localparam logic [0:0] c_st_payload = 1'b1;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       sync3_q, sync3_d;
    logic [0:0] state_q, state_d;
    logic [5:0] remaining_q, remaining_d;
    logic       key_frame_q, key_frame_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic       out_key_q, out_key_d;
    logic       out_pulse_q, out_pulse_d;
    logic       busy_q, busy_d;
    logic       frame_err_q, frame_err_d;
    logic       w_byte_event;
    logic       w_timeout;

    // sync2 is the first metastability-safe copy; sync3 only serves edge detect
    assign w_byte_event = sync2_q & ~sync3_q;

`ifdef READER_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // A byte arriving on the expiry cycle takes priority over the abort
    assign w_timeout = (state_q == c_st_payload) && !w_byte_event
                       && (tmo_cnt_q == c_tmo_last);

    always_comb begin
        tmo_cnt_d = 16'd0;
        if (state_q == c_st_payload && !w_byte_event && !w_timeout) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        sync1_d     = in_strobe;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        state_d     = state_q;
        remaining_d = remaining_q;
        key_frame_d = key_frame_q;
        out_byte_d  = 8'd0;
        out_key_d   = 1'b0;
        out_pulse_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            c_st_hdr: begin
                if (w_byte_event) begin
                    if (!in_byte[7]) begin
                        key_frame_d = in_byte[6];
                        remaining_d = in_byte[5:0];
                        state_d     = c_st_payload;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            c_st_payload: begin
                if (w_byte_event) begin
                    out_byte_d  = in_byte;
                    out_key_d   = key_frame_q;
                    out_pulse_d = 1'b1;
                    if (remaining_q == 6'd0) begin
                        state_d = c_st_hdr;
                    end else begin
                        remaining_d = remaining_q - 6'd1;
                    end
                end else if (w_timeout) begin
                    frame_err_d = 1'b1;
                    state_d     = c_st_hdr;
                end
            end
            default: begin
                state_d = c_st_hdr;
            end
        endcase

        busy_d = (state_d == c_st_payload);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            state_q     <= c_st_hdr;
            remaining_q <= 6'd0;
            key_frame_q <= 1'b0;
            out_byte_q  <= 8'd0;
            out_key_q   <= 1'b0;
            out_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            key_frame_q <= key_frame_d;
            out_byte_q  <= out_byte_d;
            out_key_q   <= out_key_d;
            out_pulse_q <= out_pulse_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign input_byte_pulsed = out_byte_q;
    assign is_key_pulsed     = out_key_q;
    assign input_pulse       = out_pulse_q;
    assign busy              = busy_q;
    assign frame_err         = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_frame_reader.sv
// ============================================================================
// Module   : tb_stream_frame_reader
// Brief    : Directed self-checking bench for stream_frame_reader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_frame_reader;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] in_byte = 8'd0;
    logic       in_strobe = 1'b0;
    logic [7:0] input_byte_pulsed;
    logic       is_key_pulsed;
    logic       input_pulse;
    logic       busy;
    logic       frame_err;

    int checks = 0;
    int failures = 0;

    logic [8:0] pulse_q[$];
    int err_cnt = 0;
    int idle_viol = 0;
    int cyc = 0;
    int last_pulse_cyc = 0;
    int prev_pulse_cyc = 0;
    int last_err_cyc = 0;

    always #5 clk = ~clk;

    stream_frame_reader #(.TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .nrst              (nrst),
        .in_byte           (in_byte),
        .in_strobe         (in_strobe),
        .input_byte_pulsed (input_byte_pulsed),
        .is_key_pulsed     (is_key_pulsed),
        .input_pulse       (input_pulse),
        .busy              (busy),
        .frame_err         (frame_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record output activity on the falling edge, away from the update edge
    always @(negedge clk) begin
        if (input_pulse) begin
            pulse_q.push_back({is_key_pulsed, input_byte_pulsed});
            prev_pulse_cyc = last_pulse_cyc;
            last_pulse_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (!input_pulse && (input_byte_pulsed != 8'd0 || is_key_pulsed != 1'b0)) begin
            idle_viol++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int low_cycles);
        @(negedge clk);
        in_byte   = b;
        in_strobe = 1'b1;
        repeat (2) @(negedge clk);
        in_strobe = 1'b0;
        repeat (low_cycles) @(negedge clk);
    endtask

    task automatic clear_log();
        pulse_q.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (input_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", input_pulse); end
        checks++; if (input_byte_pulsed !== 8'd0) begin failures++; $display("FAIL reset_byte got=%h exp=00", input_byte_pulsed); end
        checks++; if (is_key_pulsed !== 1'b0) begin failures++; $display("FAIL reset_key got=%b exp=0", is_key_pulsed); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_key_frame();
        clear_log();
        send_byte(8'h41, 3);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL key_hdr_busy got=%b exp=1", busy); end
        checks++; if (pulse_q.size() !== 0) begin failures++; $display("FAIL key_hdr_nopulse got=%0d exp=0", pulse_q.size()); end
        send_byte(8'hAA, 3);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL key_mid_busy got=%b exp=1", busy); end
        send_byte(8'h55, 3);
        checks++;
        if (pulse_q.size() !== 2) begin
            failures++; $display("FAIL key_count got=%0d exp=2", pulse_q.size());
        end else begin
            checks++; if (pulse_q[0] !== 9'h1AA) begin failures++; $display("FAIL key_p0 got=%h exp=1aa", pulse_q[0]); end
            checks++; if (pulse_q[1] !== 9'h155) begin failures++; $display("FAIL key_p1 got=%h exp=155", pulse_q[1]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL key_end_busy got=%b exp=0", busy); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL key_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_data_frame();
        int bad;
        clear_log();
        send_byte(8'h00, 3);
        send_byte(8'h3C, 3);
        checks++;
        if (pulse_q.size() !== 1) begin
            failures++; $display("FAIL data1_count got=%0d exp=1", pulse_q.size());
        end else begin
            checks++; if (pulse_q[0] !== 9'h03C) begin failures++; $display("FAIL data1_p0 got=%h exp=03c", pulse_q[0]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL data1_busy got=%b exp=0", busy); end

        clear_log();
        send_byte(8'h3F, 3);
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i), 2);
            if (i == 62) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL data64_busy63 got=%b exp=1", busy); end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pulse_q.size() !== 64) begin
            failures++; $display("FAIL data64_count got=%0d exp=64", pulse_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                if (pulse_q[i] !== {1'b0, 8'(i)}) bad++;
            end
            checks++; if (bad !== 0) begin failures++; $display("FAIL data64_values got=%0d_wrong exp=0_wrong", bad); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL data64_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reserved();
        clear_log();
        send_byte(8'h80, 3);
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL rsv_err1 got=%0d exp=1", err_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rsv_busy1 got=%b exp=0", busy); end
        send_byte(8'hC5, 3);
        checks++; if (err_cnt !== 2) begin failures++; $display("FAIL rsv_err2 got=%0d exp=2", err_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rsv_busy2 got=%b exp=0", busy); end
        checks++; if (pulse_q.size() !== 0) begin failures++; $display("FAIL rsv_nopulse got=%0d exp=0", pulse_q.size()); end
        send_byte(8'h01, 3);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rsv_next_hdr_busy got=%b exp=1", busy); end
        send_byte(8'h12, 3);
        send_byte(8'h34, 3);
        checks++;
        if (pulse_q.size() !== 2) begin
            failures++; $display("FAIL rsv_after_count got=%0d exp=2", pulse_q.size());
        end else begin
            checks++; if (pulse_q[0] !== 9'h012 || pulse_q[1] !== 9'h034) begin
                failures++; $display("FAIL rsv_after_vals got=%h,%h exp=012,034", pulse_q[0], pulse_q[1]);
            end
        end
        checks++; if (err_cnt !== 2) begin failures++; $display("FAIL rsv_err_final got=%0d exp=2", err_cnt); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h42, 3);
        send_byte(8'h11, 3);
        #2 nrst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_async_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        clear_log();
        send_byte(8'h00, 3);
        send_byte(8'h99, 3);
        checks++;
        if (pulse_q.size() !== 1) begin
            failures++; $display("FAIL rstmid_count got=%0d exp=1", pulse_q.size());
        end else begin
            checks++; if (pulse_q[0] !== 9'h099) begin failures++; $display("FAIL rstmid_p0 got=%h exp=099", pulse_q[0]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    endtask

    task automatic test_latency();
        send_byte(8'h01, 3);
        clear_log();
        @(negedge clk);
        in_byte   = 8'h5A;
        in_strobe = 1'b1;
        @(posedge clk);                 // edge k
        @(posedge clk); #1;             // edge k+1
        checks++; if (input_pulse !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", input_pulse); end
        @(posedge clk); #1;             // edge k+2
        checks++; if (input_pulse !== 1'b1 || input_byte_pulsed !== 8'h5A || is_key_pulsed !== 1'b0) begin
            failures++; $display("FAIL lat_pulse got=%b/%h/%b exp=1/5a/0", input_pulse, input_byte_pulsed, is_key_pulsed);
        end
        @(posedge clk); #1;
        checks++; if (input_pulse !== 1'b0) begin failures++; $display("FAIL lat_width got=%b exp=0", input_pulse); end
        repeat (7) @(negedge clk);
        in_strobe = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pulse_q.size() !== 1) begin failures++; $display("FAIL lat_held_once got=%0d exp=1", pulse_q.size()); end
        send_byte(8'h77, 3);
        checks++; if (pulse_q.size() !== 2 || busy !== 1'b0) begin
            failures++; $display("FAIL lat_close got=%0d/%b exp=2/0", pulse_q.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_byte(8'h00, 2);
        send_byte(8'h10, 2);
        send_byte(8'h41, 2);
        send_byte(8'h20, 2);
        send_byte(8'h21, 2);
        repeat (2) @(negedge clk);
        checks++;
        if (pulse_q.size() !== 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", pulse_q.size());
        end else begin
            checks++; if (pulse_q[0] !== 9'h010 || pulse_q[1] !== 9'h120 || pulse_q[2] !== 9'h121) begin
                failures++; $display("FAIL b2b_vals got=%h,%h,%h exp=010,120,121", pulse_q[0], pulse_q[1], pulse_q[2]);
            end
        end
        checks++; if (busy !== 1'b0 || err_cnt !== 0) begin
            failures++; $display("FAIL b2b_end got=%b/%0d exp=0/0", busy, err_cnt);
        end
    endtask

`ifdef READER_TIMEOUT_EN
    task automatic test_timeout();
        int waited;
        clear_log();
        send_byte(8'h41, 3);
        send_byte(8'hAB, 3);
        waited = 0;
        while (err_cnt == 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL tmo_err got=%0d exp=1", err_cnt); end
        checks++; if (last_err_cyc - last_pulse_cyc !== 16) begin
            failures++; $display("FAIL tmo_delay got=%0d exp=16", last_err_cyc - last_pulse_cyc);
        end
        checks++; if (busy !== 1'b0 || pulse_q.size() !== 1) begin
            failures++; $display("FAIL tmo_state got=%b/%0d exp=0/1", busy, pulse_q.size());
        end

        clear_log();
        send_byte(8'h41, 3);
        send_byte(8'hAB, 3);
        repeat (10) @(negedge clk);
        send_byte(8'hCD, 3);
        repeat (20) @(negedge clk);
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL tmo_race_err got=%0d exp=0", err_cnt); end
        checks++;
        if (pulse_q.size() !== 2) begin
            failures++; $display("FAIL tmo_race_count got=%0d exp=2", pulse_q.size());
        end else begin
            checks++; if (pulse_q[1] !== 9'h1CD || last_pulse_cyc - prev_pulse_cyc !== 16) begin
                failures++; $display("FAIL tmo_race_byte got=%h/%0d exp=1cd/16", pulse_q[1], last_pulse_cyc - prev_pulse_cyc);
            end
        end
    endtask
`endif

    task automatic test_idle_zero();
        checks++; if (idle_viol !== 0) begin failures++; $display("FAIL idle_outputs_zero got=%0d exp=0", idle_viol); end
    endtask

    initial begin
        test_reset();
        test_key_frame();
        test_data_frame();
        test_reserved();
        test_reset_mid();
        test_latency();
        test_back_to_back();
`ifdef READER_TIMEOUT_EN
        test_timeout();
`endif
        test_idle_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
